// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: fetch-stage state encodings,
// instruction field positions and the opcode values decoded by the control unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;

  localparam logic [1:0] OPC_ALU    = 2'b00;
  localparam logic [1:0] OPC_LOAD   = 2'b01;
  localparam logic [1:0] OPC_STORE  = 2'b10;
  localparam logic [1:0] OPC_BRANCH = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_imem.sv
// Single-port instruction RAM, synchronous read and write, no reset.
// The read register only updates on a read strobe so it can double as IF/ID storage.
module imem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: byte-serial program load, PC sequencing with
// branch redirect and stall, and the IF/ID register feeding decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int IMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic                load_valid,
  input  logic [7:0]          load_data,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [7:0]          instruction,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                instr_valid,
  output logic [PC_WIDTH:0]   prog_len,
  output logic [1:0]          state
);

  fetch_state_t st, st_next;

  // Carry bit keeps a run that falls off the top of memory from wrapping to 0.
  logic [PC_WIDTH:0] pc;
  logic              fetched;
  logic [7:0]        rdata;
  logic              len_full;
  logic              clr_len, do_write, do_start, do_branch, do_fetch, do_halt;
  logic [PC_WIDTH-1:0] mem_addr;

  assign len_full = (prog_len == (PC_WIDTH+1)'(IMEM_DEPTH));
  assign state    = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      st <= ST_IDLE;
    else
      st <= st_next;
  end

  always_comb begin
    st_next   = st;
    clr_len   = 1'b0;
    do_write  = 1'b0;
    do_start  = 1'b0;
    do_branch = 1'b0;
    do_fetch  = 1'b0;
    do_halt   = 1'b0;
    case (st)
      ST_IDLE, ST_HALT: begin
        if (load_en) begin
          st_next = ST_LOAD;
          clr_len = 1'b1;
        end else if (start && (prog_len != '0)) begin
          st_next  = ST_RUN;
          do_start = 1'b1;
        end
      end
      ST_LOAD: begin
        do_write = load_valid && !len_full;
        if (!load_en)
          st_next = ST_IDLE;
      end
      ST_RUN: begin
        if (branch_taken) begin
          do_branch = 1'b1;
        end else if (!stall) begin
          if (pc >= prog_len) begin
            do_halt = 1'b1;
            st_next = ST_HALT;
          end else begin
            do_fetch = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      prog_len    <= '0;
      fetched     <= 1'b0;
    end else begin
      if (clr_len)
        prog_len <= '0;
      else if (do_write)
        prog_len <= prog_len + (PC_WIDTH+1)'(1);

      if (do_start)
        pc <= '0;
      else if (do_branch)
        pc <= {1'b0, branch_target};
      else if (do_fetch)
        pc <= pc + (PC_WIDTH+1)'(1);

      if (do_branch || do_halt)
        instr_valid <= 1'b0;
      else if (do_fetch)
        instr_valid <= 1'b1;

      if (do_fetch) begin
        pc_out  <= pc[PC_WIDTH-1:0];
        fetched <= 1'b1;
      end
    end
  end

  assign mem_addr = do_write ? prog_len[PC_WIDTH-1:0] : pc[PC_WIDTH-1:0];

  imem #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (PC_WIDTH)
  ) u_imem (
    .clk   (clk),
    .we    (do_write),
    .re    (do_fetch),
    .addr  (mem_addr),
    .wdata (load_data),
    .rdata (rdata)
  );

  // The RAM read register holds the fetched byte; mask it until the first fetch after reset.
  assign instruction = fetched ? rdata : 8'h00;

endmodule
